// File: rtl/weights_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to sequential weights-memory port-A addresses.
// Optional running checksum of written words is enabled by defining WEIGHTS_LOADER_CHECKSUM_EN.
module weights_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t           state;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= '0;
            count    <= '0;
            words    <= '0;
            in_ready <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            mem_sel  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                // Partial word is dropped; words already written stay in memory.
                state    <= IDLE;
                byte_idx <= '0;
                words    <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                mem_sel  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            byte_idx <= '0;
                            words    <= '0;
                            mem_addr <= '0;
                            if (word_count == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                count    <= (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
                                state    <= FILL;
                                in_ready <= 1'b1;
                                busy     <= 1'b1;
                                mem_sel  <= 1'b0;
                            end
                        end
                    end
                    FILL: begin
                        if (in_valid && in_ready) begin
                            mem_data[{byte_idx, 3'b000} +: 8] <= in_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                state    <= WRITE;
                                in_ready <= 1'b0;
                                mem_wren <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        words <= words + CNT_W'(1);
                        if (words + CNT_W'(1) == count) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            mem_sel <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            byte_idx <= '0;
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    // A write already on the bus completes even if abort arrives in the same cycle, so it is summed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == IDLE && start && !abort) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum + mem_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_weights_loader.sv
// Self-checking bench for weights_loader: table-driven loads plus randomized loads against a byte-queue reference model.
module tb_weights_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [12:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        mem_sel;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    weights_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_sel(mem_sel),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_data_log[$];
    logic [11:0] wr_addr_log[$];

    typedef struct {
        int wc;
        int vmode;        // 0 always valid, 1 pattern 1-0-0-1, 2 random
        int abort_after;  // bytes accepted before abort, -1 for none
        bit start_mid;
        bit seq;
        int exp_writes;
        bit exp_done;
    } vec_t;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, " mem_addr"}, {20'd0, mem_addr}, 32'd0);
        check({tag, " mem_data"}, mem_data, 32'd0);
        check({tag, " mem_wren"}, {31'd0, mem_wren}, 32'd0);
        check({tag, " mem_sel"}, {31'd0, mem_sel}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " checksum"}, checksum, 32'd0);
    endtask

    // Drives one load and compares every write against words rebuilt from the accepted bytes.
    task automatic run_load(input vec_t v, input string tag);
        logic [7:0]  bytes_q[$];
        logic [7:0]  nextb = 8'h11;
        logic [31:0] w;
        logic [31:0] sum = 32'd0;
        int nbytes = 0, writes = 0, dones = 0;
        int last_wr_cyc = -10, done_cyc = -1, byte4_cyc = -10, idle_after = 0;
        int eff, budget, cyc;
        bit bad_sel = 0, bad_timing = 0, busy_seen = 0, aborted = 0, vbit;
        eff = (v.wc > 4096) ? 4096 : v.wc;
        budget = eff * 12 + 50;
        wr_data_log.delete();
        wr_addr_log.delete();
        start = 1'b1;
        word_count = 13'(v.wc);
        step;
        start = 1'b0;
        for (cyc = 1; cyc < budget; cyc++) begin
            if (busy) busy_seen = 1;
            if (in_ready && mem_sel) bad_sel = 1;
            if (mem_wren) begin
                if (mem_sel) bad_sel = 1;
                if (cyc != byte4_cyc + 1) bad_timing = 1;
                if (bytes_q.size() >= 4 * writes + 4)
                    w = {bytes_q[4*writes+3], bytes_q[4*writes+2], bytes_q[4*writes+1], bytes_q[4*writes]};
                else
                    w = 32'hDEAD_BEEF;
                check({tag, " wr_addr"}, {20'd0, mem_addr}, 32'(writes));
                check({tag, " wr_data"}, mem_data, w);
                wr_data_log.push_back(mem_data);
                wr_addr_log.push_back(mem_addr);
                sum += w;
                writes++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (aborted) begin
                idle_after++;
                if (idle_after == 1) begin
                    check({tag, " abort busy"}, {31'd0, busy}, 32'd0);
                    check({tag, " abort mem_sel"}, {31'd0, mem_sel}, 32'd1);
                    check({tag, " abort in_ready"}, {31'd0, in_ready}, 32'd0);
                end
                if (idle_after == 10) break;
            end else if (dones > 0 && cyc > done_cyc + 2) begin
                break;
            end
            abort = 1'b0;
            in_valid = 1'b0;
            in_data = 8'($urandom);
            start = 1'b0;
            if (!aborted && v.abort_after >= 0 && nbytes == v.abort_after) begin
                abort = 1'b1;
                aborted = 1;
            end else if (!aborted) begin
                case (v.vmode)
                    0: vbit = 1'b1;
                    1: vbit = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: vbit = ($urandom_range(0, 3) != 0);
                endcase
                in_valid = vbit;
                if (v.seq) in_data = nextb;
                if (vbit && in_ready) begin
                    bytes_q.push_back(in_data);
                    nbytes++;
                    if (nbytes % 4 == 0) byte4_cyc = cyc;
                    nextb = nextb + 8'd1;
                end
            end
            if (v.start_mid && cyc == 7) begin
                start = 1'b1;
                word_count = 13'd1;
            end
            step;
        end
        abort = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        check({tag, " write count"}, 32'(writes), 32'(v.exp_writes));
        check({tag, " done count"}, 32'(dones), 32'(v.exp_done));
        check({tag, " mem_sel ownership"}, {31'd0, bad_sel}, 32'd0);
        check({tag, " wren after 4th byte"}, {31'd0, bad_timing}, 32'd0);
        if (v.exp_done && v.exp_writes > 0)
            check({tag, " done after last write"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
        if (v.wc == 0) begin
            check({tag, " zero done latency"}, 32'(done_cyc), 32'd1);
            check({tag, " zero busy"}, {31'd0, busy_seen}, 32'd0);
        end
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
        check({tag, " checksum"}, checksum, sum);
`else
        check({tag, " checksum"}, checksum, 32'd0);
`endif
        step;
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{wc: 2,    vmode: 0, abort_after: -1, start_mid: 0, seq: 1, exp_writes: 2,    exp_done: 1};
        tbl[1] = '{wc: 2,    vmode: 1, abort_after: -1, start_mid: 0, seq: 1, exp_writes: 2,    exp_done: 1};
        tbl[2] = '{wc: 0,    vmode: 0, abort_after: -1, start_mid: 0, seq: 0, exp_writes: 0,    exp_done: 1};
        tbl[3] = '{wc: 3,    vmode: 0, abort_after: 6,  start_mid: 1, seq: 0, exp_writes: 1,    exp_done: 0};
        tbl[4] = '{wc: 7,    vmode: 2, abort_after: -1, start_mid: 1, seq: 0, exp_writes: 7,    exp_done: 1};
        tbl[5] = '{wc: 1,    vmode: 2, abort_after: -1, start_mid: 0, seq: 0, exp_writes: 1,    exp_done: 1};
        tbl[6] = '{wc: 5000, vmode: 0, abort_after: -1, start_mid: 0, seq: 0, exp_writes: 4096, exp_done: 1};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        word_count = '0;
        in_valid = 1'b0;
        in_data = '0;
        #1;
        check_reset_outputs("reset");
        step;
        rst = 1'b0;
        step;

        // Byte ordering and checksum against fixed words.
        rv = tbl[0];
        run_load(rv, "two_word");
        if (wr_data_log.size() == 2) begin
            check("two_word word0", wr_data_log[0], 32'h14131211);
            check("two_word word1", wr_data_log[1], 32'h18171615);
        end else begin
            check("two_word logged writes", 32'(wr_data_log.size()), 32'd2);
        end
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
        check("two_word checksum const", checksum, 32'h2C2A2826);
`endif

        for (int i = 0; i < 7; i++) begin
            run_load(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].wc == 5000 && wr_addr_log.size() > 0)
                check("full last addr", {20'd0, wr_addr_log[wr_addr_log.size()-1]}, 32'h0000_0FFF);
        end

        for (int i = 0; i < 4; i++) begin
            rv = '{wc: int'($urandom_range(1, 20)), vmode: 2, abort_after: -1, start_mid: 0, seq: 0,
                   exp_writes: 0, exp_done: 1};
            rv.exp_writes = rv.wc;
            run_load(rv, $sformatf("rand%0d", i));
        end

        // abort and start together in IDLE: nothing starts.
        start = 1'b1;
        abort = 1'b1;
        word_count = 13'd2;
        step;
        start = 1'b0;
        abort = 1'b0;
        check("abort+start busy", {31'd0, busy}, 32'd0);
        check("abort+start in_ready", {31'd0, in_ready}, 32'd0);
        check("abort+start mem_sel", {31'd0, mem_sel}, 32'd1);
        step;
        check("abort+start done", {31'd0, done}, 32'd0);

        // Reset mid-load returns immediately to reset values and stops writes.
        start = 1'b1;
        word_count = 13'd3;
        step;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        for (int i = 0; i < 6; i++) step;
        rst = 1'b1;
        #1;
        check_reset_outputs("midload reset");
        for (int i = 0; i < 4; i++) begin
            step;
            check("reset no wren", {31'd0, mem_wren}, 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
